// File: rtl/phys_step_sequencer.sv
// rtl/phys_step_sequencer.sv - one-pass read/update/write-back sequencer over the object dynamics RAM
`ifndef DF_DEC
`define DF_DEC 8
`endif
`ifndef OBJ_DYN_WIDTH
`define OBJ_DYN_WIDTH 64
`endif

module phys_step_sequencer #(
  parameter int NUM_OBJ    = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst_n,
  input  logic                             start,
  input  logic signed [`DF_DEC+1:0]        time_step,
  input  logic        [ADDR_WIDTH:0]       obj_count,
  output logic                             busy,
  output logic                             done,
  output logic        [ADDR_WIDTH-1:0]     ram_addr,
  output logic                             ram_we,
  output logic        [`OBJ_DYN_WIDTH-1:0] ram_wdata,
  input  logic        [`OBJ_DYN_WIDTH-1:0] ram_rdata,
  output logic        [`OBJ_DYN_WIDTH-1:0] upd_dyn,
  output logic signed [`DF_DEC+1:0]        upd_ts,
  input  logic        [`OBJ_DYN_WIDTH-1:0] upd_result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CAPTURE,
    S_APPLY,
    S_WRITE,
    S_FINISH
  } state_t;

  // Count is one bit wider than the address so NUM_OBJ == 2**ADDR_WIDTH is representable.
  localparam logic [ADDR_WIDTH:0] NUM_OBJ_C = (ADDR_WIDTH+1)'(NUM_OBJ);
  // WAIT exits after RD_LATENCY-1 cycles; the counter starts at 0 on entry.
  localparam logic [1:0]          WAIT_LAST = 2'(RD_LATENCY - 2);

  state_t                     r_state;
  state_t                     w_next;
  logic [ADDR_WIDTH-1:0]      r_idx;
  logic [ADDR_WIDTH:0]        r_cnt;
  logic [1:0]                 r_wait;
  logic signed [`DF_DEC+1:0]  r_ts;
  logic [`OBJ_DYN_WIDTH-1:0]  r_obj;
  logic [`OBJ_DYN_WIDTH-1:0]  r_wb;
  logic [ADDR_WIDTH:0]        w_cnt_clamp;
  logic                       w_last;
  logic                       w_wait_done;

  assign w_cnt_clamp = (obj_count > NUM_OBJ_C) ? NUM_OBJ_C : obj_count;
  assign w_last      = ({1'b0, r_idx} == (r_cnt - (ADDR_WIDTH+1)'(1)));
  assign w_wait_done = (r_wait == WAIT_LAST);

  // The same index addresses both the read and the write-back of an object.
  assign ram_addr = r_idx;
  assign upd_dyn  = r_obj;
  assign upd_ts   = r_ts;

  // State register; reset abandons any step in flight.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state strobes; only WRITE drives the RAM write port.
  always_comb begin
    w_next    = r_state;
    busy      = 1'b1;
    done      = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_next = (w_cnt_clamp == '0) ? S_FINISH : S_READ;
        end
      end
      S_READ: begin
        w_next = (RD_LATENCY > 1) ? S_WAIT : S_CAPTURE;
      end
      S_WAIT: begin
        if (w_wait_done) begin
          w_next = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_next = S_APPLY;
      end
      S_APPLY: begin
        w_next = S_WRITE;
      end
      S_WRITE: begin
        ram_we    = 1'b1;
        ram_wdata = r_wb;
        w_next    = w_last ? S_FINISH : S_READ;
      end
      S_FINISH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: latch step parameters on an accepted start, move one object word per pass.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_idx  <= '0;
      r_cnt  <= '0;
      r_wait <= '0;
      r_ts   <= '0;
      r_obj  <= '0;
      r_wb   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ts  <= time_step;
            r_cnt <= w_cnt_clamp;
            r_idx <= '0;
          end
        end
        S_READ: begin
          r_wait <= '0;
        end
        S_WAIT: begin
          r_wait <= r_wait + 2'd1;
        end
        S_CAPTURE: begin
          r_obj <= ram_rdata;
        end
        S_APPLY: begin
          r_wb <= upd_result;
        end
        S_WRITE: begin
          if (!w_last) begin
            r_idx <= r_idx + ADDR_WIDTH'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phys_step_sequencer.sv
// tb/tb_phys_step_sequencer.sv - scoreboard bench for phys_step_sequencer at read latencies 2, 1 and 4
`timescale 1ns/1ps

module tb_phys_step_sequencer;

  typedef struct {
    int          inst;
    int          addr;
    logic [63:0] data;
  } wr_t;

  logic        clk;
  logic        rst_n;
  logic        load_mem;
  logic [2:0]  start_v;
  logic signed [9:0] ts;
  logic [4:0]  cnt;

  logic        busy_v  [3];
  logic        done_v  [3];
  logic        we_v    [3];
  logic [3:0]  addr_v  [3];
  logic [63:0] wdata_v [3];
  logic [63:0] rdata_v [3];
  logic [63:0] dyn_v   [3];
  logic [9:0]  uts_v   [3];
  logic [63:0] res_v   [3];

  logic [63:0] mem   [3][16];
  logic [63:0] rpipe [3][4];

  wr_t  exp_q[$];
  logic [9:0] exp_ts [3];
  int   writes   [3];
  int   done_cnt [3];
  int   busy_run [3];
  int   last_len [3];
  int   n_chk;
  int   n_pass;

  // External update unit stand-in: integrate position by velocity, mix time step into vel_x.
  function automatic logic [63:0] upd_f(input logic [63:0] d, input logic [9:0] t);
    logic [15:0] px, py, vx, vy;
    {px, py, vx, vy} = d;
    return {px + vx, py + vy, vx ^ {6'b0, t}, vy};
  endfunction

  function automatic logic [63:0] init_word(input int i, input int a);
    return {16'h1000 + 16'(a * 37 + i), 16'h2000 + 16'(a * 11), 16'(a * 5 + 3 + i), 16'hFFF0 - 16'(a)};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    phys_step_sequencer #(
      .NUM_OBJ(8),
      .ADDR_WIDTH(4),
      .RD_LATENCY(L)
    ) u_dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .start     (start_v[g]),
      .time_step (ts),
      .obj_count (cnt),
      .busy      (busy_v[g]),
      .done      (done_v[g]),
      .ram_addr  (addr_v[g]),
      .ram_we    (we_v[g]),
      .ram_wdata (wdata_v[g]),
      .ram_rdata (rdata_v[g]),
      .upd_dyn   (dyn_v[g]),
      .upd_ts    (uts_v[g]),
      .upd_result(res_v[g])
    );
    assign res_v[g]   = upd_f(dyn_v[g], uts_v[g]);
    assign rdata_v[g] = rpipe[g][L-1];
  end

  // RAM models: synchronous write, read data delayed through a pipeline of the instance latency.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (load_mem) begin
        for (int a = 0; a < 16; a++) mem[i][a] <= init_word(i, a);
      end else if (we_v[i]) begin
        mem[i][addr_v[i]] <= wdata_v[i];
      end
      rpipe[i][0] <= mem[i][addr_v[i]];
      for (int k = 1; k < 4; k++) rpipe[i][k] <= rpipe[i][k-1];
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Output monitor: step length, done pulses, and write-back scoreboard.
  always @(negedge clk) begin
    int k;
    int pend;
    for (int i = 0; i < 3; i++) begin
      if (busy_v[i]) busy_run[i]++;
      if (done_v[i]) begin
        last_len[i] = busy_run[i];
        done_cnt[i]++;
      end
      if (!busy_v[i]) busy_run[i] = 0;
      if (we_v[i]) begin
        writes[i]++;
        k = -1;
        pend = 0;
        foreach (exp_q[j]) begin
          if (exp_q[j].inst == i) begin
            pend++;
            if (k < 0) k = j;
          end
        end
        check_val("wr_pending", 64'(pend != 0), 64'd1);
        if (k >= 0) begin
          check_val("wr_addr", 64'(addr_v[i]), 64'(exp_q[k].addr));
          check_val("wr_data", wdata_v[i], exp_q[k].data);
          check_val("wr_ts", 64'(uts_v[i]), 64'(exp_ts[i]));
          exp_q.delete(k);
        end
      end
    end
  end

  task automatic do_step(input int inst, input logic [9:0] t, input int n);
    int  m;
    wr_t e;
    m = (n > 8) ? 8 : n;
    for (int a = 0; a < m; a++) begin
      e.inst = inst;
      e.addr = a;
      e.data = upd_f(mem[inst][a], t);
      exp_q.push_back(e);
    end
    exp_ts[inst]   = t;
    writes[inst]   = 0;
    done_cnt[inst] = 0;
    ts             = t;
    cnt            = 5'(n);
    start_v[inst]  = 1'b1;
    @(negedge clk);
    start_v[inst]  = 1'b0;
    #1;
  endtask

  task automatic wait_done(input int inst, input int budget);
    int c;
    c = 0;
    while (done_cnt[inst] == 0 && c < budget) begin
      @(negedge clk);
      #1;
      c++;
    end
    check_val("done_seen", 64'(done_cnt[inst]), 64'd1);
    @(negedge clk);
    #1;
    check_val("busy_after", 64'(busy_v[inst]), 64'd0);
  endtask

  task automatic end_check(input int inst, input int nw, input int len);
    int pend;
    pend = 0;
    foreach (exp_q[j]) if (exp_q[j].inst == inst) pend++;
    check_val("step_len", 64'(last_len[inst]), 64'(len));
    check_val("wr_count", 64'(writes[inst]), 64'(nw));
    check_val("sb_left", 64'(pend), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] old_w [4];
    logic [63:0] new0;
    int          c;
    int          pend;

    rst_n    = 1'b0;
    load_mem = 1'b0;
    start_v  = 3'b000;
    ts       = '0;
    cnt      = '0;
    n_chk    = 0;
    n_pass   = 0;
    for (int i = 0; i < 3; i++) begin
      writes[i] = 0; done_cnt[i] = 0; busy_run[i] = 0; last_len[i] = 0; exp_ts[i] = '0;
    end

    repeat (2) @(negedge clk);
    load_mem = 1'b1;
    @(negedge clk);
    load_mem = 1'b0;
    #1;
    check_val("rst_busy",  64'(busy_v[0]), 64'd0);
    check_val("rst_done",  64'(done_v[0]), 64'd0);
    check_val("rst_we",    64'(we_v[0]), 64'd0);
    check_val("rst_addr",  64'(addr_v[0]), 64'd0);
    check_val("rst_wdata", wdata_v[0], 64'd0);
    check_val("rst_dyn",   dyn_v[0], 64'd0);
    check_val("rst_ts",    64'(uts_v[0]), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;
    // Start accepted on the very first edge after reset release; time step 1.0.
    do_step(0, 10'h100, 3);
    wait_done(0, 40);
    end_check(0, 3, 16);

    do_step(0, 10'h055, 0);
    wait_done(0, 10);
    end_check(0, 0, 1);

    do_step(0, 10'($urandom_range(1023)), 5);
    wait_done(0, 60);
    end_check(0, 5, 26);

    do_step(0, 10'h3F0, 1);
    wait_done(0, 20);
    end_check(0, 1, 6);

    do_step(0, 10'h080, 12);
    wait_done(0, 80);
    end_check(0, 8, 41);

    // Second start in cycle 3 of a step must be ignored entirely.
    do_step(0, 10'h100, 3);
    repeat (2) @(negedge clk);
    ts         = 10'sh1AA;
    cnt        = 5'd7;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    #1;
    wait_done(0, 40);
    end_check(0, 3, 16);
    repeat (3) @(negedge clk);
    #1;
    check_val("repulse_idle", 64'(busy_v[0]), 64'd0);
    check_val("repulse_wr",   64'(writes[0]), 64'd3);

    // Reset during the write-back of object 1 of a 4-object step.
    for (int a = 0; a < 4; a++) old_w[a] = mem[0][a];
    new0 = upd_f(old_w[0], 10'h0C3);
    do_step(0, 10'h0C3, 4);
    c = 0;
    while (writes[0] < 1 && c < 40) begin
      @(negedge clk);
      #1;
      c++;
    end
    check_val("obj0_written", 64'(writes[0]), 64'd1);
    repeat (5) @(posedge clk);
    #2;
    check_val("in_write1_we",   64'(we_v[0]), 64'd1);
    check_val("in_write1_addr", 64'(addr_v[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check_val("abort_we",   64'(we_v[0]), 64'd0);
    check_val("abort_busy", 64'(busy_v[0]), 64'd0);
    check_val("abort_done", 64'(done_v[0]), 64'd0);
    pend = 0;
    foreach (exp_q[j]) if (exp_q[j].inst == 0) pend++;
    check_val("abort_pending", 64'(pend), 64'd3);
    for (int j = exp_q.size() - 1; j >= 0; j--) if (exp_q[j].inst == 0) exp_q.delete(j);
    repeat (3) @(negedge clk);
    #1;
    check_val("abort_no_done", 64'(done_cnt[0]), 64'd0);
    check_val("abort_wr",      64'(writes[0]), 64'd1);
    check_val("ram_obj0_new",  mem[0][0], new0);
    for (int a = 1; a < 4; a++) check_val("ram_obj_old", mem[0][a], old_w[a]);
    @(negedge clk);
    rst_n = 1'b1;

    // Latency 1 and latency 4 instances.
    do_step(1, 10'h100, 2);
    wait_done(1, 30);
    end_check(1, 2, 9);
    do_step(2, 10'h200, 2);
    wait_done(2, 40);
    end_check(2, 2, 15);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
